// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a UART program image, writes it to RAM, releases core reset on a good checksum
module uart_boot_loader #(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned BaudRate       = 115_200,
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned MaxWords       = 16384
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_i,
  input  logic        uart_rx_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  output logic        core_rst_no,
  output logic        busy_o,
  output logic        load_done_o,
  output logic        load_err_o
);
  localparam int unsigned ClksPerBit = ClockFrequency / BaudRate;
  localparam int unsigned CntW = $clog2(ClksPerBit + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(ClksPerBit / 2 - 1);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR} state_e;
  rx_state_e rx_state_q;
  logic rx_meta_q, rx_sync_q, rx_prev_q, rx_valid_q, rx_ferr_q;
  logic [CntW-1:0] rx_cnt_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_shift_q;
  state_e state_q;
  logic [7:0] len_hi_q, csum_q;
  logic [15:0] len_q, idx_q, len_d;
  logic [1:0] bcnt_q;
  logic [23:0] asm_q;
  logic [31:0] addr_q, wdata_q, word_d;
  logic req_q, ok_q, done_q, err_q, granted;
  assign len_d = {len_hi_q, rx_shift_q};
  assign word_d = {rx_shift_q, asm_q};
  assign granted = req_q & mem_gnt_i;
  assign mem_req_o = req_q;
  assign mem_we_o = req_q;
  assign mem_be_o = {4{req_q}};
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign core_rst_no = done_q;
  assign load_done_o = done_q;
  assign load_err_o = err_q;
  assign busy_o = state_q inside {LEN_HI, LEN_LO, DATA, CHECK};
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      rx_valid_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      rx_cnt_q <= rx_cnt_q + CntW'(1);
      case (rx_state_q)
        RX_IDLE: if (rx_prev_q && !rx_sync_q) begin
          rx_cnt_q <= '0;
          rx_state_q <= RX_START;
        end
        // a line that is high again at mid-start-bit was only a glitch
        RX_START: if (rx_cnt_q == CntHalf) begin
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
          rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_cnt_q == CntFull) begin
          rx_cnt_q <= '0;
          rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_q <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
        end
        default: if (rx_cnt_q == CntFull) begin
          rx_valid_q <= rx_sync_q;
          rx_ferr_q <= !rx_sync_q;
          rx_state_q <= RX_IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state_q <= IDLE;
      len_hi_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      bcnt_q <= '0;
      asm_q <= '0;
      csum_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      req_q <= 1'b0;
      ok_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (granted) req_q <= 1'b0;
      if (rx_ferr_q && state_q != DONE && state_q != ERROR) begin
        state_q <= ERROR;
        err_q <= 1'b1;
        req_q <= 1'b0;
      end else case (state_q)
        IDLE: if (rx_valid_q && rx_shift_q == 8'hA5) state_q <= LEN_HI;
        LEN_HI: if (rx_valid_q) begin
          len_hi_q <= rx_shift_q;
          state_q <= LEN_LO;
        end
        LEN_LO: if (rx_valid_q) begin
          len_q <= len_d;
          idx_q <= '0;
          bcnt_q <= '0;
          csum_q <= '0;
          ok_q <= 1'b0;
          err_q <= 32'(len_d) > MaxWords;
          state_q <= 32'(len_d) > MaxWords ? ERROR : len_d == 16'd0 ? CHECK : DATA;
        end
        DATA: if (rx_valid_q) begin
          csum_q <= csum_q ^ rx_shift_q;
          asm_q <= {rx_shift_q, asm_q[23:8]};
          bcnt_q <= bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            // a new word while the previous write is still waiting is an overrun
            if (req_q && !mem_gnt_i) begin
              state_q <= ERROR;
              err_q <= 1'b1;
              req_q <= 1'b0;
            end else begin
              req_q <= 1'b1;
              addr_q <= BaseAddr + {14'd0, idx_q, 2'b00};
              wdata_q <= word_d;
              idx_q <= idx_q + 16'd1;
              if (idx_q == len_q - 16'd1) state_q <= CHECK;
            end
          end
        end
        CHECK: if (rx_valid_q) begin
          if (rx_shift_q != csum_q) begin
            state_q <= ERROR;
            err_q <= 1'b1;
            req_q <= 1'b0;
          end else if (!req_q || mem_gnt_i) begin
            state_q <= DONE;
            done_q <= 1'b1;
          end else ok_q <= 1'b1;
        end else if (ok_q && granted) begin
          state_q <= DONE;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: table-driven byte streams plus a mid-load reset sequence
module tb_uart_boot_loader;
  localparam int Cpb = 16;
  localparam logic [9:0] GL = 10'h200;
  localparam logic [9:0] BS = 10'h100;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, gnt;
  logic mem_req, mem_we, core_rst_n, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_be;
  always #5 clk = ~clk;
  uart_boot_loader #(.ClockFrequency(1_600_000), .BaudRate(100_000), .BaseAddr(32'h0010_0000), .MaxWords(2)) dut (
    .clk_sys_i(clk), .rst_sys_i(rst), .uart_rx_i(rx), .mem_req_o(mem_req), .mem_gnt_i(gnt),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .core_rst_no(core_rst_n), .busy_o(busy), .load_done_o(done), .load_err_o(err)
  );
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  bit stall_mode = 1'b0;
  int base = 0, exp_nwr = 0;
  int wr_cnt = 0, stab_err = 0, early = 0, run = 0;
  logic [31:0] wa [0:63], wd [0:63];
  logic pr = 1'b0, pg = 1'b0;
  logic [31:0] pa = '0, pd = '0;
  initial begin
    int sc;
    sc = 0;
    gnt = 1'b1;
    forever begin
      tick(1);
      if (!stall_mode) gnt = 1'b1;
      else if (mem_req) begin
        gnt = (sc == 50);
        sc++;
      end else begin
        gnt = 1'b0;
        sc = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (mem_req === 1'b1 && gnt === 1'b1) begin
      wa[wr_cnt % 64] = mem_addr;
      wd[wr_cnt % 64] = mem_wdata;
      wr_cnt++;
    end
    if (!rst && pr && !pg && !err && (mem_req !== 1'b1 || mem_addr !== pa || mem_wdata !== pd)) stab_err++;
    run = (mem_req === 1'b1) ? run + 1 : 0;
    if (!stall_mode && run > 1) stab_err++;
    if (mem_req === 1'b1 && (mem_be !== 4'hF || mem_we !== 1'b1)) stab_err++;
    if (mem_req === 1'b0 && (mem_we !== 1'b0 || mem_be !== 4'h0)) stab_err++;
    if (done === 1'b1 && wr_cnt - base < exp_nwr) early++;
    pr = (mem_req === 1'b1);
    pg = (gnt === 1'b1);
    pa = mem_addr;
    pd = mem_wdata;
  end
  task automatic send(input logic [9:0] b);
    if (b[9]) begin
      rx = 1'b0;
      tick(5);
      rx = 1'b1;
      tick(2 * Cpb);
    end else begin
      rx = 1'b0;
      tick(Cpb);
      for (int i = 0; i < 8; i++) begin
        rx = b[i];
        tick(Cpb);
      end
      rx = ~b[8];
      tick(Cpb);
      rx = 1'b1;
      tick(2);
    end
  endtask
  typedef struct {int first; int n; bit stall; bit done; bit err; int nwr;} vec_t;
  vec_t v [0:15];
  int nv = 0;
  logic [9:0] st [0:255];
  int wp = 0;
  task automatic put(input logic [9:0] b);
    st[wp] = b;
    wp++;
  endtask
  task automatic body(input bit g);
    put(10'h0A5);
    if (g) put(GL);
    put(10'h000); put(10'h002);
    put(10'h078); put(10'h056); put(10'h034); put(10'h012);
    put(10'h0EF); put(10'h0BE); put(10'h0AD); put(10'h0DE);
  endtask
  task automatic add(input int f, input bit s, input bit d, input bit e, input int nw);
    v[nv] = '{f, wp - f, s, d, e, nw};
    nv++;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " req"}, 32'(mem_req), 32'd0);
    chk({tag, " we"}, 32'(mem_we), 32'd0);
    chk({tag, " addr"}, mem_addr, 32'd0);
    chk({tag, " wdata"}, mem_wdata, 32'd0);
    chk({tag, " be"}, 32'(mem_be), 32'd0);
    chk({tag, " core_rst_n"}, 32'(core_rst_n), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
  endtask
  task automatic chk_words(input string tag, input int b0, input int nw);
    if (nw > 0) begin
      chk({tag, " w0 addr"}, wa[b0 % 64], 32'h0010_0000);
      chk({tag, " w0 data"}, wd[b0 % 64], 32'h1234_5678);
    end
    if (nw > 1) begin
      chk({tag, " w1 addr"}, wa[(b0 + 1) % 64], 32'h0010_0004);
      chk({tag, " w1 data"}, wd[(b0 + 1) % 64], 32'hDEAD_BEEF);
    end
  endtask
  initial begin
    int f, s0, e0;
    string tag;
    // the XOR of the eight data bytes of the two-word image is 0x2A
    f = wp; body(0); put(10'h02A); add(f, 0, 1, 0, 2);
    f = wp; body(0); put(10'h02A); add(f, 1, 1, 0, 2);
    f = wp; put(10'h000); put(10'h0FF); body(0); put(10'h03D); put(10'h055); put(10'h0A5); add(f, 0, 0, 1, 2);
    f = wp; put(10'h0A5); put(10'h000); put(10'h000); put(10'h000); add(f, 0, 1, 0, 0);
    f = wp; put(10'h0A5); put(10'h040); put(10'h001); add(f, 0, 0, 1, 0);
    f = wp; put(10'h0A5); put(10'h000); put(10'h003); add(f, 0, 0, 1, 0);
    f = wp; body(1); put(10'h02A); add(f, 0, 1, 0, 2);
    f = wp; put(10'h0A5); put(10'h000); put(10'h002); put(10'h078); put(10'h056); put(BS | 10'h034); add(f, 0, 0, 1, 0);
    tick(3);
    chk_reset("reset");
    for (int i = 0; i < nv; i++) begin
      rst = 1'b1;
      stall_mode = v[i].stall;
      tick(2);
      rst = 1'b0;
      base = wr_cnt;
      exp_nwr = v[i].nwr;
      s0 = stab_err;
      e0 = early;
      for (int j = 0; j < v[i].n; j++) send(st[v[i].first + j]);
      tick(120);
      tag = $sformatf("v%0d", i);
      chk({tag, " done"}, 32'(done), 32'(v[i].done));
      chk({tag, " err"}, 32'(err), 32'(v[i].err));
      chk({tag, " core_rst_n"}, 32'(core_rst_n), 32'(v[i].done));
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " writes"}, 32'(wr_cnt - base), 32'(v[i].nwr));
      chk({tag, " port protocol"}, 32'(stab_err - s0), 32'd0);
      chk({tag, " done before grant"}, 32'(early - e0), 32'd0);
      chk_words(tag, base, v[i].nwr);
    end
    rst = 1'b1;
    stall_mode = 1'b0;
    tick(2);
    rst = 1'b0;
    base = wr_cnt;
    exp_nwr = 2;
    for (int j = 0; j < 8; j++) send(st[j]);
    chk("midrst busy before", 32'(busy), 32'd1);
    chk("midrst writes before", 32'(wr_cnt - base), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_reset("midrst");
    base = wr_cnt;
    s0 = stab_err;
    for (int j = 0; j < 12; j++) send(st[j]);
    tick(120);
    chk("midrst reload done", 32'(done), 32'd1);
    chk("midrst reload err", 32'(err), 32'd0);
    chk("midrst reload writes", 32'(wr_cnt - base), 32'd2);
    chk("midrst port protocol", 32'(stab_err - s0), 32'd0);
    chk_words("midrst", base, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
